// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one single-port frame-buffer RAM between
// the VGA display prefetch and a small buffered pixel-write FIFO.
module frame_buffer_arbiter #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_IN,
  input  logic        RESET,
  input  logic [9:0]  xCoord,
  input  logic [9:0]  yCoord,
  output logic [7:0]  PIXEL_OUT,
  output logic [14:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [7:0]  MEM_DIN,
  input  logic [7:0]  MEM_DOUT,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [14:0] WR_ADDR,
  input  logic [7:0]  WR_DATA,
  input  logic        VBLANK_ONLY,
  output logic        WR_ERR
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [14:0] PIX_TOTAL = 15'd19200;

  logic [9:0]    xt;
  logic [9:0]    yt;
  logic          slot;
  logic          slot_d;
  logic [14:0]   row;
  logic [14:0]   col;
  logic [14:0]   slot_addr;

  logic [14:0]   fa [FIFO_DEPTH];
  logic [7:0]    fd [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;
  logic [14:0]   head_addr;
  logic          head_ok;

  // Position two pixels ahead; the last pair of a line targets the next line.
  always_comb begin
    xt = xCoord + 10'd2;
    yt = yCoord;
    if (xCoord == 10'(H_TOTAL - 2)) begin
      xt = '0;
      yt = (yCoord == 10'(V_TOTAL - 1)) ? '0 : yCoord + 10'd1;
    end
  end

  assign slot = (xCoord[1:0] == 2'b10)
             && (xt < 10'(H_ACTIVE))
             && (yt < 10'(V_ACTIVE));

  assign row       = 15'(yt[9:2]);
  assign col       = 15'(xt[9:2]);
  assign slot_addr = (row << 7) + (row << 5) + col;

  assign push      = WR_VALID && WR_READY && !RESET;
  assign head_addr = fa[rptr];
  assign head_ok   = head_addr < PIX_TOTAL;
  assign pop       = !RESET && !slot && (count != '0)
                  && (!VBLANK_ONLY || (yCoord >= 10'(V_ACTIVE)));

  // Occupancy after this edge; simultaneous push and pop cancel.
  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + CW'(1);
    else if (!push && pop)
      cnt_nxt = count - CW'(1);
  end

  // RAM port mux: display fetch first, then FIFO drain, else idle.
  always_comb begin
    MEM_ADDR = '0;
    MEM_WE   = 1'b0;
    MEM_DIN  = '0;
    if (slot) begin
      MEM_ADDR = slot_addr;
    end else if (pop && head_ok) begin
      MEM_ADDR = head_addr;
      MEM_DIN  = fd[rptr];
      MEM_WE   = 1'b1;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      WR_READY <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count    <= cnt_nxt;
      WR_READY <= cnt_nxt < CW'(FIFO_DEPTH);
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK_IN) begin
    if (push) begin
      fa[wptr] <= WR_ADDR;
      fd[wptr] <= WR_DATA;
    end
  end

  // Display pipeline, pixel latch and sticky bad-address flag.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      slot_d    <= 1'b0;
      PIXEL_OUT <= '0;
      WR_ERR    <= 1'b0;
    end else begin
      slot_d <= slot;
      if (xCoord[1:0] == 2'b11)
        PIXEL_OUT <= slot_d ? MEM_DOUT : '0;
      if (pop && !head_ok)
        WR_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: randomized and directed scoreboard bench
// with a registered RAM model and a screen-level pixel reference.
module tb_frame_buffer_arbiter;

  logic        CLK_IN = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  xCoord = '0;
  logic [9:0]  yCoord = '0;
  logic [7:0]  PIXEL_OUT;
  logic [14:0] MEM_ADDR;
  logic        MEM_WE;
  logic [7:0]  MEM_DIN;
  logic [7:0]  MEM_DOUT = '0;
  logic        WR_VALID = 1'b0;
  logic        WR_READY;
  logic [14:0] WR_ADDR = '0;
  logic [7:0]  WR_DATA = '0;
  logic        VBLANK_ONLY = 1'b0;
  logic        WR_ERR;

  frame_buffer_arbiter dut (
    .CLK_IN(CLK_IN), .RESET(RESET),
    .xCoord(xCoord), .yCoord(yCoord),
    .PIXEL_OUT(PIXEL_OUT),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .VBLANK_ONLY(VBLANK_ONLY), .WR_ERR(WR_ERR)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic [7:0] ram [0:19199];
  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  pix_chk = 1'b0;
  bit  scan_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Linear screen position two pixels ahead, wrapping over the frame.
  function automatic int tgt(int x, int y);
    return (y * 800 + x + 2) % (800 * 525);
  endfunction

  function automatic bit is_slot(int x, int y);
    int t;
    t = tgt(x, y);
    return (x % 4 == 2) && (t % 800 < 640) && (t / 800 < 480);
  endfunction

  function automatic int slot_addr(int x, int y);
    int t;
    t = tgt(x, y);
    return ((t / 800) / 4) * 160 + (t % 800) / 4;
  endfunction

  function automatic int exp_pix(int x, int y);
    if (x < 640 && y < 480)
      return int'(ram[(y / 4) * 160 + x / 4]);
    return 0;
  endfunction

  // Registered single-port RAM: read-before-write.
  always @(posedge CLK_IN) begin
    if (MEM_ADDR < 15'd19200) begin
      MEM_DOUT <= ram[MEM_ADDR];
      if (MEM_WE) ram[MEM_ADDR] = MEM_DIN;
    end
  end

  // Scoreboard producer: every accepted in-range write is expected in order.
  always @(posedge CLK_IN) begin
    if (RESET)
      exp_q.delete();
    else if (WR_VALID && WR_READY && WR_ADDR < 15'd19200)
      exp_q.push_back('{int'(WR_ADDR), int'(WR_DATA)});
  end

  // Monitor: RAM port activity and displayed pixels against the model.
  always @(negedge CLK_IN) begin
    wr_t w;
    if (!RESET && is_slot(xCoord, yCoord))
      chk("slot_addr", MEM_ADDR, slot_addr(xCoord, yCoord));
    if (MEM_WE) begin
      if (RESET) chk("we_in_reset", 1, 0);
      if (!RESET && is_slot(xCoord, yCoord)) chk("we_in_slot", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_we", MEM_ADDR, -1);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", MEM_ADDR, w.a);
        chk("wr_data", MEM_DIN, w.d);
      end
    end
    if (pix_chk)
      chk("pixel", PIXEL_OUT, exp_pix(xCoord, yCoord));
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
    if (scan_en) begin
      if (xCoord == 10'd799) begin
        xCoord = '0;
        yCoord = (yCoord == 10'd524) ? 10'd0 : yCoord + 10'd1;
      end else begin
        xCoord = xCoord + 10'd1;
      end
    end
  endtask

  initial begin
    int ys[6];
    int k;
    int n;
    bit acc;

    for (int i = 0; i < 19200; i++) ram[i] = 8'($urandom);
    ram[1] = 8'hE3;

    // Reset with a writer already offering.
    RESET = 1'b1;
    WR_VALID = 1'b1;
    WR_ADDR = 15'd3;
    WR_DATA = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pix", PIXEL_OUT, 0);
      chk("rst_ready", WR_READY, 0);
      chk("rst_we", MEM_WE, 0);
      chk("rst_err", WR_ERR, 0);
    end
    RESET = 1'b0;
    WR_VALID = 1'b0;
    tick();
    chk("ready_after_rst", WR_READY, 1);

    // Directed fetch addresses.
    xCoord = 10'd2;   yCoord = 10'd0;   #1;
    chk("fetch_2_0", MEM_ADDR, 1);
    chk("fetch_2_0_we", MEM_WE, 0);
    xCoord = 10'd798; yCoord = 10'd3;   #1;
    chk("fetch_798_3", MEM_ADDR, 160);
    xCoord = 10'd798; yCoord = 10'd524; #1;
    chk("fetch_798_524", MEM_ADDR, 0);

    // x=638 is not a slot: a queued write drains there one cycle after push.
    xCoord = 10'd638; yCoord = 10'd5;
    WR_VALID = 1'b1;
    WR_ADDR = 15'd77;
    WR_DATA = 8'h5A;
    tick();
    WR_VALID = 1'b0;
    #1;
    chk("drain_638_we", MEM_WE, 1);
    chk("drain_638_addr", MEM_ADDR, 77);
    tick();

    // Pixel path over whole lines, primed from the end of the previous line.
    ys[0] = 0;
    ys[1] = 4 + int'($urandom_range(0, 470));
    ys[2] = 479;
    ys[3] = 490;
    ys[4] = 524;
    ys[5] = int'($urandom_range(0, 479));
    scan_en = 1'b1;
    foreach (ys[j]) begin
      pix_chk = 1'b0;
      xCoord = 10'd790;
      yCoord = (ys[j] == 0) ? 10'd524 : 10'(ys[j] - 1);
      for (int i = 0; i < 10; i++) tick();
      pix_chk = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if (ys[j] == 0 && xCoord >= 10'd4 && xCoord <= 10'd7)
          chk("pix_e3", PIXEL_OUT, 8'hE3);
        if (ys[j] == 490 && xCoord == 10'd100)
          chk("pix_blank_490", PIXEL_OUT, 0);
        tick();
      end
      pix_chk = 1'b0;
    end

    // Contention: continuous writes while the display fetches an active line.
    VBLANK_ONLY = 1'b0;
    xCoord = '0;
    yCoord = 10'd10;
    k = 0;
    for (int i = 0; i < 600; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR = 15'(k);
      WR_DATA = 8'(k);
      acc = WR_READY;
      tick();
      if (acc) k++;
    end
    WR_VALID = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("cont_drained", exp_q.size(), 0);
    chk("cont_throughput", int'(k >= 400), 1);
    for (int a = 0; a < k; a++)
      chk("cont_ram", ram[a], a & 255);

    // Backpressure in tear-free mode.
    scan_en = 1'b0;
    VBLANK_ONLY = 1'b1;
    xCoord = 10'd1;
    yCoord = 10'd100;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR = 15'(1000 + n);
      WR_DATA = 8'(8'hA0 + n);
      acc = WR_READY;
      tick();
      if (acc) n++;
      chk("vblank_hold", MEM_WE, 0);
    end
    WR_VALID = 1'b0;
    chk("bp_accepted", n, 4);
    chk("bp_ready_low", WR_READY, 0);
    yCoord = 10'd480;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_we", MEM_WE, 1);
      if (i == 1) chk("bp_ready_back", WR_READY, 1);
      tick();
    end
    chk("bp_empty_we", MEM_WE, 0);

    // Out-of-range address sets the sticky error and is not written.
    VBLANK_ONLY = 1'b0;
    yCoord = 10'd490;
    chk("err_init", WR_ERR, 0);
    WR_VALID = 1'b1;
    WR_ADDR = 15'd19200;
    WR_DATA = 8'd11;
    tick();
    chk("err_no_we", MEM_WE, 0);
    WR_ADDR = 15'd5;
    WR_DATA = 8'h55;
    tick();
    WR_VALID = 1'b0;
    #1;
    chk("err_set", WR_ERR, 1);
    chk("err_next_we", MEM_WE, 1);
    chk("err_next_addr", MEM_ADDR, 5);
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky", WR_ERR, 1);

    // Mid-operation reset discards queued writes.
    VBLANK_ONLY = 1'b1;
    yCoord = 10'd100;
    for (int i = 0; i < 3; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR = 15'(2000 + i);
      WR_DATA = 8'(i);
      tick();
    end
    WR_VALID = 1'b0;
    RESET = 1'b1;
    yCoord = 10'd480;
    #1;
    chk("rst_mid_we", MEM_WE, 0);
    tick();
    chk("rst_mid_err", WR_ERR, 0);
    chk("rst_mid_ready", WR_READY, 0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_flushed", MEM_WE, 0);
    end
    chk("rst_ready_back", WR_READY, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
